nrzi_encoder: RTL and testbench
===============================

Name: nrzi_encoder

Overview:
NRZI transmitter that pairs with the existing NRZI decoder. It takes parallel bytes over a valid/ready handshake, optionally prepends a preamble of ones, and serializes each byte LSB first. Each bit cell lasts CLKS_PER_BIT refclk cycles. A 1 toggles the line at the start of its cell; a 0 holds the line. It sits at the transmit end of the optical/serial link; its output drives the pin that a remote decoder samples at the same oversampling ratio.

Parameters:
CLKS_PER_BIT, 8, refclk cycles per bit cell; must be 2 or more; matches the decoder's 8x oversampling.
DATA_W, 8, bits per word accepted on tx_data.
PREAMBLE_BITS, 4, number of 1-bits sent before the first word of a burst; 0 disables the preamble.

Ports:
refclk  in  1  sole clock; everything is on its rising edge.
reset  in  1  synchronous, active-high reset.
tx_data  in  DATA_W  word to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a word; equals the inverse of hold_full.
out  out  1  registered NRZI line output.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state=IDLE, out=0, hold_full=0 (so tx_ready=1), busy=0.
  - cell_cnt=0, bit_idx=0, pre_cnt=0.
- Reset mid-burst aborts immediately. In-flight and held data are discarded. out returns to 0.
- Holding register (one entry):
  - A handshake happens when tx_valid and tx_ready are both high. That cycle, hold_data<=tx_data and hold_full<=1.
  - hold_full clears when the shifter loads from the hold register. A load and an accept never coincide, because tx_ready=0 while hold_full=1.
- Cell timer: cell_cnt counts 0..CLKS_PER_BIT-1 in PREAMBLE and DATA, then wraps. cell_end = (cell_cnt==CLKS_PER_BIT-1). cell_cnt is held at 0 in IDLE.
- Bit emission: on the cycle a new cell starts, out<=out^bit. out is stable for the rest of the cell.
- State machine:
  - IDLE:
    - Condition: hold_full=1.
    - If PREAMBLE_BITS>0: go to PREAMBLE, pre_cnt<=PREAMBLE_BITS-1, and toggle out (first preamble 1).
    - Otherwise: load shifter from hold, clear hold_full, go to DATA, and emit bit0.
    - Latency: accept at cycle k gives hold_full at k+1 and the first out change at k+2.
  - PREAMBLE:
    - At cell_end with pre_cnt>0: decrement pre_cnt and toggle out.
    - At cell_end with pre_cnt==0 and hold_full=1: load shifter, clear hold_full, go to DATA, emit bit0.
    - hold_full is always 1 here, since the word that started the burst is still held.
  - DATA:
    - At cell_end with bit_idx<DATA_W-1: bit_idx++ and emit the next shifter bit.
    - At cell_end with bit_idx==DATA_W-1 and hold_full=1: load the next word and emit its bit0 with no gap and no preamble (back-to-back).
    - At cell_end with bit_idx==DATA_W-1 and hold_full=0: go to IDLE. out holds its level and busy drops in the same cycle.
- Line level is continuous across words and bursts. The polarity after a burst is whatever the data left; it is never forced back to 0 except by reset.
- Throughput: one word per DATA_W*CLKS_PER_BIT cycles when tx_valid is held high.

Decomposition:
- Shared package nrzi_pkg holds:
  - the state enum (IDLE, PREAMBLE, DATA);
  - the constant NRZI_CLKS_PER_BIT=8, also used by the decoder side.
- One natural sub-module, nrzi_bit_timer:
  - Inputs: refclk, reset, run.
  - Output: cell_end.
  - Holds the cell counter and clears when run=0.
- The FSM, shifter and hold register stay in nrzi_encoder.

Test Plan:
- Default params, send 0xA5 from out=0:
  - Preamble levels 1,0,1,0, then data levels 1,1,0,0,0,1,1,0.
  - First toggle occurs 2 cycles after the handshake; each level lasts 8 cycles.
  - busy is high for 96 cycles, and out ends at 0.
- PREAMBLE_BITS=0, send 0x00: out stays 0 for the whole burst; busy is high for exactly 64 cycles.
- tx_valid held high with 0x00, 0xFF, 0x0F:
  - tx_ready is low while the hold register is full.
  - All three words go out contiguously: one preamble, 192 data cycles, no idle gap.
  - Each word's bit0 cell starts exactly 64 cycles after the previous word's.
- Loopback into the NRZI decoder at 8x with a random 256-byte stream:
  - The decoder's sampled bits (out captured at oe) reproduce the preamble ones plus every byte, LSB first.
- Reset asserted mid-word (cycle 40 of 0xFF), with a second word held:
  - Next cycle: out=0, busy=0, tx_ready=1.
  - No further toggles occur; the held word is not sent.
- Idle hold: after a burst that ends at out=1, wait 100 cycles with no tx_valid. out stays 1 and busy stays 0.

Source files
------------

// File: rtl/nrzi_pkg.sv
// Shared NRZI link definitions: transmitter state encoding, oversampling ratio
// and the line-level update rule used by both ends of the link.
package nrzi_pkg;

   localparam int NRZI_CLKS_PER_BIT = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2
   } nrzi_state_t;

   // NRZI: a 1 flips the line, a 0 keeps it.
   function automatic logic nrzi_next_level(input logic level, input logic bit_val);
      return level ^ bit_val;
   endfunction

endpackage

// File: rtl/nrzi_bit_timer.sv
// Bit-cell timer: counts refclk cycles within one cell and flags the last cycle.
// The count is held at zero whenever run is low, so a new burst always starts a fresh cell.
module nrzi_bit_timer
   import nrzi_pkg::*;
#(
   parameter int CLKS_PER_BIT = NRZI_CLKS_PER_BIT
) (
   input  logic refclk,
   input  logic reset,
   input  logic run,
   output logic cell_end
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cell_cnt_q;
   logic [CNT_W-1:0] cell_cnt_d;

   always_comb begin
      cell_cnt_d = cell_cnt_q;
      if (!run) begin
         cell_cnt_d = '0;
      end else if (cell_cnt_q == LAST_CNT) begin
         cell_cnt_d = '0;
      end else begin
         cell_cnt_d = cell_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge refclk) begin
      if (reset) begin
         cell_cnt_q <= '0;
      end else begin
         cell_cnt_q <= cell_cnt_d;
      end
   end

   assign cell_end = run && (cell_cnt_q == LAST_CNT);

endmodule

// File: rtl/nrzi_encoder.sv
// NRZI transmitter: one-word holding register, optional preamble of ones per burst,
// LSB-first serializer with back-to-back word chaining and a registered line output.
module nrzi_encoder
   import nrzi_pkg::*;
#(
   parameter int CLKS_PER_BIT  = NRZI_CLKS_PER_BIT,
   parameter int DATA_W        = 8,
   parameter int PREAMBLE_BITS = 4
) (
   input  logic              refclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              out,
   output logic              busy
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic [PRE_W-1:0] PRE_LOAD = (PREAMBLE_BITS > 0) ? PRE_W'(PREAMBLE_BITS - 1) : '0;

   nrzi_state_t       state_q, state_d;
   logic              out_q, out_d;
   logic              busy_q, busy_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;

   logic run;
   logic cell_end;
   logic load_shift;

   assign run = (state_q != IDLE);

   nrzi_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .refclk   (refclk),
      .reset    (reset),
      .run      (run),
      .cell_end (cell_end)
   );

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      pre_cnt_d   = pre_cnt_q;
      load_shift  = 1'b0;

      // Accept and load are mutually exclusive: accept needs an empty holder, load a full one.
      if (tx_valid && !hold_full_q) begin
         hold_data_d = tx_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               if (PREAMBLE_BITS > 0) begin
                  state_d   = PREAMBLE;
                  pre_cnt_d = PRE_LOAD;
                  out_d     = nrzi_next_level(out_q, 1'b1);
               end else begin
                  load_shift = 1'b1;
               end
            end
         end
         PREAMBLE: begin
            if (cell_end) begin
               if (pre_cnt_q != '0) begin
                  pre_cnt_d = pre_cnt_q - 1'b1;
                  out_d     = nrzi_next_level(out_q, 1'b1);
               end else if (hold_full_q) begin
                  load_shift = 1'b1;
               end
            end
         end
         DATA: begin
            if (cell_end) begin
               if (bit_idx_q != LAST_IDX) begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  out_d     = nrzi_next_level(out_q, shift_q[0]);
                  shift_d   = shift_q >> 1;
               end else if (hold_full_q) begin
                  load_shift = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Loading emits bit0 immediately; the shifter keeps the remaining bits LSB-aligned.
      if (load_shift) begin
         state_d     = DATA;
         hold_full_d = 1'b0;
         shift_d     = hold_data_q >> 1;
         bit_idx_d   = '0;
         out_d       = nrzi_next_level(out_q, hold_data_q[0]);
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge refclk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_q       <= 1'b0;
         busy_q      <= 1'b0;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         shift_q     <= '0;
         bit_idx_q   <= '0;
         pre_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         busy_q      <= busy_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         pre_cnt_q   <= pre_cnt_d;
      end
   end

   assign tx_ready = ~hold_full_q;
   assign out      = out_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_nrzi_encoder.sv
// Bench for nrzi_encoder: a preamble instance and a no-preamble instance; a line monitor
// decodes the preamble instance at mid-cell and checks bits and busy against a queue/model.
module tb_nrzi_encoder;

   localparam int CPB = 8;
   localparam int DW  = 8;
   localparam int PB  = 4;

   logic          refclk     = 1'b0;
   logic          reset      = 1'b1;
   logic [DW-1:0] tx_data_a  = '0;
   logic [DW-1:0] tx_data_b  = '0;
   logic          tx_valid_a = 1'b0;
   logic          tx_valid_b = 1'b0;
   logic          tx_ready_a, out_a, busy_a;
   logic          tx_ready_b, out_b, busy_b;

   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc     = 0;
   logic exp_q[$];

   always #5 refclk = ~refclk;
   always @(posedge refclk) cyc <= cyc + 1;

   nrzi_encoder #(
      .CLKS_PER_BIT  (CPB),
      .DATA_W        (DW),
      .PREAMBLE_BITS (PB)
   ) dut_a (
      .refclk   (refclk),
      .reset    (reset),
      .tx_data  (tx_data_a),
      .tx_valid (tx_valid_a),
      .tx_ready (tx_ready_a),
      .out      (out_a),
      .busy     (busy_a)
   );

   nrzi_encoder #(
      .CLKS_PER_BIT  (CPB),
      .DATA_W        (DW),
      .PREAMBLE_BITS (0)
   ) dut_b (
      .refclk   (refclk),
      .reset    (reset),
      .tx_data  (tx_data_b),
      .tx_valid (tx_valid_b),
      .tx_ready (tx_ready_b),
      .out      (out_b),
      .busy     (busy_b)
   );

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   // Pushes expected bits at each handshake of dut_a, predicts busy, and decodes the line mid-cell.
   task automatic scoreboard();
      int   rem       = 0;
      int   start_dly = 0;
      int   phase     = 0;
      logic busy_prev = 1'b0;
      logic lvl_prev  = 1'b0;
      logic got, want;
      forever begin
         @(negedge refclk);
         if (reset) begin
            rem       = 0;
            start_dly = 0;
            phase     = 0;
            busy_prev = 1'b0;
            exp_q.delete();
         end else begin
            vec_cnt++;
            if (busy_a !== (rem > 0)) begin
               err_cnt++;
               $display("FAIL busy_model cyc=%0d: busy=%b, expected %b", cyc, busy_a, (rem > 0));
            end
            if (busy_a) begin
               phase = busy_prev ? (phase + 1) % CPB : 0;
               if (phase == CPB / 2) begin
                  got      = out_a ^ lvl_prev;
                  lvl_prev = out_a;
                  vec_cnt++;
                  if (exp_q.size() == 0) begin
                     err_cnt++;
                     $display("FAIL line_bit cyc=%0d: decoded %b, expected no bit", cyc, got);
                  end else begin
                     want = exp_q.pop_front();
                     if (got !== want) begin
                        err_cnt++;
                        $display("FAIL line_bit cyc=%0d: decoded %b, expected %b", cyc, got, want);
                     end
                  end
               end
            end else begin
               lvl_prev = out_a;
            end
            busy_prev = busy_a;
            if (tx_valid_a && tx_ready_a) begin
               if (rem >= 2) begin
                  rem += DW * CPB;
               end else begin
                  for (int i = 0; i < PB; i++) exp_q.push_back(1'b1);
                  start_dly = 2;
               end
               for (int i = 0; i < DW; i++) exp_q.push_back(tx_data_a[i]);
            end
            if (rem > 0) rem--;
            if (start_dly > 0) begin
               start_dly--;
               if (start_dly == 0) rem = (PB + DW) * CPB;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      @(negedge refclk);
      vec_cnt++;
      if (out_a !== 1'b0 || busy_a !== 1'b0 || tx_ready_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL reset_a: out=%b busy=%b ready=%b, expected 0 0 1", out_a, busy_a, tx_ready_a);
      end
      vec_cnt++;
      if (out_b !== 1'b0 || busy_b !== 1'b0 || tx_ready_b !== 1'b1) begin
         err_cnt++;
         $display("FAIL reset_b: out=%b busy=%b ready=%b, expected 0 0 1", out_b, busy_b, tx_ready_b);
      end
      $display("reset: out_a=%b busy_a=%b ready_a=%b", out_a, busy_a, tx_ready_a);
   endtask

   task automatic test_preamble_a5();
      logic lv [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      step();
      tx_data_a  = 8'hA5;
      tx_valid_a = 1'b1;
      @(negedge refclk);
      vec_cnt++;
      if (tx_ready_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL a5_handshake: ready=%b, expected 1", tx_ready_a);
      end
      step();
      tx_valid_a = 1'b0;
      @(negedge refclk);
      vec_cnt++;
      if (out_a !== 1'b0 || busy_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL a5_latency: out=%b busy=%b one cycle after handshake, expected 0 0", out_a, busy_a);
      end
      for (int c = 0; c < 96; c++) begin
         @(negedge refclk);
         vec_cnt++;
         if (out_a !== lv[c / CPB] || busy_a !== 1'b1) begin
            err_cnt++;
            $display("FAIL a5_level c=%0d: out=%b busy=%b, expected %b 1", c, out_a, busy_a, lv[c / CPB]);
         end
      end
      @(negedge refclk);
      vec_cnt++;
      if (out_a !== 1'b0 || busy_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL a5_end: out=%b busy=%b, expected 0 0", out_a, busy_a);
      end
      $display("preamble_a5: burst of 0xA5 ended out=%b busy=%b", out_a, busy_a);
   endtask

   task automatic test_no_preamble();
      logic [7:0] words [2] = '{8'h00, 8'h03};
      logic       lvl       = 1'b0;
      foreach (words[w]) begin
         step();
         tx_data_b  = words[w];
         tx_valid_b = 1'b1;
         @(negedge refclk);
         vec_cnt++;
         if (tx_ready_b !== 1'b1) begin
            err_cnt++;
            $display("FAIL nopre_handshake w=%0d: ready=%b, expected 1", w, tx_ready_b);
         end
         step();
         tx_valid_b = 1'b0;
         @(negedge refclk);
         vec_cnt++;
         if (out_b !== lvl || busy_b !== 1'b0) begin
            err_cnt++;
            $display("FAIL nopre_latency w=%0d: out=%b busy=%b, expected %b 0", w, out_b, busy_b, lvl);
         end
         for (int c = 0; c < DW * CPB; c++) begin
            if (c % CPB == 0) lvl = lvl ^ words[w][c / CPB];
            @(negedge refclk);
            vec_cnt++;
            if (out_b !== lvl || busy_b !== 1'b1) begin
               err_cnt++;
               $display("FAIL nopre_level w=%0d c=%0d: out=%b busy=%b, expected %b 1", w, c, out_b, busy_b, lvl);
            end
         end
         @(negedge refclk);
         vec_cnt++;
         if (out_b !== lvl || busy_b !== 1'b0) begin
            err_cnt++;
            $display("FAIL nopre_end w=%0d: out=%b busy=%b, expected %b 0", w, out_b, busy_b, lvl);
         end
         $display("no_preamble: word 0x%02h sent, out=%b", words[w], out_b);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h0F};
      int         hs_cyc [3] = '{0, 0, 0};
      int         w        = 0;
      int         busy_run = 0;
      int         guard    = 0;
      bit         done     = 1'b0;
      step();
      tx_data_a  = words[0];
      tx_valid_a = 1'b1;
      while (!done && guard < 600) begin
         @(negedge refclk);
         guard++;
         if (busy_a) busy_run++;
         else if (busy_run > 0) done = 1'b1;
         if (!done && tx_valid_a && tx_ready_a) begin
            hs_cyc[w] = cyc;
            w++;
            step();
            if (w < 3) tx_data_a = words[w];
            else tx_valid_a = 1'b0;
            vec_cnt++;
            if (tx_ready_a !== 1'b0) begin
               err_cnt++;
               $display("FAIL b2b_hold_full w=%0d: ready=%b, expected 0", w, tx_ready_a);
            end
         end
      end
      tx_valid_a = 1'b0;
      vec_cnt++;
      if (!done || w != 3) begin
         err_cnt++;
         $display("FAIL b2b_complete: done=%0d words=%0d, expected 1 3", done, w);
      end
      vec_cnt++;
      if (busy_run != (PB + 3 * DW) * CPB) begin
         err_cnt++;
         $display("FAIL b2b_busy_len: %0d cycles, expected %0d", busy_run, (PB + 3 * DW) * CPB);
      end
      vec_cnt++;
      if (hs_cyc[1] - hs_cyc[0] != 2 + PB * CPB || hs_cyc[2] - hs_cyc[1] != DW * CPB) begin
         err_cnt++;
         $display("FAIL b2b_spacing: %0d %0d, expected %0d %0d",
                  hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1], 2 + PB * CPB, DW * CPB);
      end
      $display("back_to_back: 3 words, busy %0d cycles", busy_run);
   endtask

   task automatic test_idle_hold();
      int guard = 0;
      bit seen  = 1'b0;
      step();
      tx_data_a  = 8'h01;
      tx_valid_a = 1'b1;
      step();
      tx_valid_a = 1'b0;
      while (guard < 300 && !(seen && !busy_a)) begin
         @(negedge refclk);
         guard++;
         if (busy_a) seen = 1'b1;
      end
      vec_cnt++;
      if (!seen || busy_a !== 1'b0 || out_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL idle_end: seen=%0d busy=%b out=%b, expected 1 0 1", seen, busy_a, out_a);
      end
      for (int c = 0; c < 100; c++) begin
         @(negedge refclk);
         vec_cnt++;
         if (out_a !== 1'b1 || busy_a !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_hold c=%0d: out=%b busy=%b, expected 1 0", c, out_a, busy_a);
         end
      end
      $display("idle_hold: line held at %b for 100 cycles", out_a);
   endtask

   task automatic test_reset_mid_word();
      step();
      tx_data_a  = 8'hFF;
      tx_valid_a = 1'b1;
      @(negedge refclk);
      vec_cnt++;
      if (tx_ready_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_handshake: ready=%b, expected 1", tx_ready_a);
      end
      step();
      tx_data_a = 8'h55;
      repeat (73) step();
      reset      = 1'b1;
      tx_valid_a = 1'b0;
      @(negedge refclk);
      vec_cnt++;
      if (out_a !== 1'b1 || busy_a !== 1'b1 || tx_ready_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL rst_before: out=%b busy=%b ready=%b, expected 1 1 0", out_a, busy_a, tx_ready_a);
      end
      step();
      reset = 1'b0;
      @(negedge refclk);
      vec_cnt++;
      if (out_a !== 1'b0 || busy_a !== 1'b0 || tx_ready_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL rst_after: out=%b busy=%b ready=%b, expected 0 0 1", out_a, busy_a, tx_ready_a);
      end
      for (int c = 0; c < 100; c++) begin
         @(negedge refclk);
         vec_cnt++;
         if (out_a !== 1'b0 || busy_a !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_quiet c=%0d: out=%b busy=%b, expected 0 0", c, out_a, busy_a);
         end
      end
      $display("reset_mid_word: aborted, out=%b busy=%b", out_a, busy_a);
   endtask

   task automatic test_loopback();
      int n     = 0;
      int guard = 0;
      step();
      tx_data_a  = 8'($urandom_range(0, 255));
      tx_valid_a = 1'b1;
      while (n < 256 && guard < 256 * DW * CPB + 500) begin
         @(negedge refclk);
         guard++;
         if (tx_valid_a && tx_ready_a) begin
            n++;
            step();
            if (n < 256) tx_data_a = 8'($urandom_range(0, 255));
            else tx_valid_a = 1'b0;
         end
      end
      tx_valid_a = 1'b0;
      guard = 0;
      while (busy_a && guard < 1000) begin
         @(negedge refclk);
         guard++;
      end
      @(negedge refclk);
      vec_cnt++;
      if (n != 256 || busy_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL loopback_done: words=%0d busy=%b, expected 256 0", n, busy_a);
      end
      vec_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL loopback_leftover: %0d bits not seen, expected 0", exp_q.size());
      end
      $display("loopback: %0d random words decoded", n);
   endtask

   initial begin
      fork
         scoreboard();
      join_none
      test_reset();
      test_preamble_a5();
      test_no_preamble();
      test_back_to_back();
      test_idle_hold();
      test_reset_mid_word();
      test_loopback();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
